multi_cycle_ctrl: RTL and testbench

Multicycle control unit for the CPU top. Sequences each instruction through the phases IF, ID, EXE, MEM and WB using a registered state machine. Drives every write-enable and mux-select of the multicycle datapath (PC, IR, register file, ALU, data memory) from the current state and the IR opcode. Also keeps a retired-instruction counter for bench observation.

---
 rtl/multi_cycle_ctrl_if.sv | 30 +++
 rtl/multi_cycle_ctrl.sv | 109 ++++++++++
 tb/tb_multi_cycle_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: control unit <-> multicycle datapath signal bundle
interface multi_cycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0] opcode;
  logic zero;
  logic [2:0] state;
  logic PCWre;
  logic IRWre;
  logic RegWre;
  logic mRD;
  logic mWR;
  logic ALUSrcB;
  logic DBDataSrc;
  logic WrRegDSrc;
  logic ExtSel;
  logic [1:0] RegDst;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic illegal;
  logic [CNT_W-1:0] instr_cnt;
  modport master (
    input opcode, zero,
    output state, PCWre, IRWre, RegWre, mRD, mWR, ALUSrcB, DBDataSrc, WrRegDSrc,
    ExtSel, RegDst, PCSrc, ALUOp, illegal, instr_cnt
  );
  modport slave (
    output opcode, zero,
    input state, PCWre, IRWre, RegWre, mRD, mWR, ALUSrcB, DBDataSrc, WrRegDSrc,
    ExtSel, RegDst, PCSrc, ALUOp, illegal, instr_cnt
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: IF/ID/EXE/MEM/WB sequencer and datapath control decode
module multi_cycle_ctrl #(parameter int CNT_W = 32) (
  input logic CLK,
  input logic RST,
  multi_cycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IF = 3'b000, S_ID = 3'b001, S_EXE_LS = 3'b010, S_MEM = 3'b011,
    S_WB_LD = 3'b100, S_EXE_BR = 3'b101, S_EXE_AL = 3'b110, S_WB_AL = 3'b111
  } state_t;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR = 6'b010000, OP_AND = 6'b010001, OP_ORI = 6'b010010;
  localparam logic [5:0] OP_SLT = 6'b100110, OP_SW = 6'b110000, OP_LW = 6'b110001;
  localparam logic [5:0] OP_BEQ = 6'b110100, OP_J = 6'b111000, OP_JR = 6'b111001;
  localparam logic [5:0] OP_JAL = 6'b111010, OP_HALT = 6'b111111;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic op_add, op_sub, op_addi, op_or, op_and, op_ori, op_slt;
  logic op_sw, op_lw, op_beq, op_j, op_jr, op_jal, op_halt;
  logic is_r, is_alu, is_jump, legal;
  logic pc_wre, ir_wre, reg_wre, m_rd, m_wr, ill;
  assign op_add = bus.opcode == OP_ADD;
  assign op_sub = bus.opcode == OP_SUB;
  assign op_addi = bus.opcode == OP_ADDI;
  assign op_or = bus.opcode == OP_OR;
  assign op_and = bus.opcode == OP_AND;
  assign op_ori = bus.opcode == OP_ORI;
  assign op_slt = bus.opcode == OP_SLT;
  assign op_sw = bus.opcode == OP_SW;
  assign op_lw = bus.opcode == OP_LW;
  assign op_beq = bus.opcode == OP_BEQ;
  assign op_j = bus.opcode == OP_J;
  assign op_jr = bus.opcode == OP_JR;
  assign op_jal = bus.opcode == OP_JAL;
  assign op_halt = bus.opcode == OP_HALT;
  assign is_r = op_add | op_sub | op_or | op_and | op_slt;
  assign is_alu = is_r | op_addi | op_ori;
  assign is_jump = op_j | op_jr | op_jal;
  assign legal = is_alu | op_lw | op_sw | op_beq | is_jump | op_halt;
  // state register; reset aborts any instruction straight back to fetch
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IF;
    else state_q <= state_d;
  end
  // next state and per-phase strobes; PC write lands in the last cycle of each instruction
  always_comb begin
    state_d = S_IF;
    pc_wre = 1'b0;
    ir_wre = 1'b0;
    reg_wre = 1'b0;
    m_rd = 1'b0;
    m_wr = 1'b0;
    ill = 1'b0;
    case (state_q)
      S_IF: begin
        state_d = S_ID;
        ir_wre = 1'b1;
      end
      S_ID: begin
        state_d = op_halt ? S_ID : op_beq ? S_EXE_BR : (op_lw | op_sw) ? S_EXE_LS :
                  is_alu ? S_EXE_AL : S_IF;
        pc_wre = is_jump | !legal;
        reg_wre = op_jal;
        ill = !legal;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL: begin
        pc_wre = 1'b1;
        reg_wre = 1'b1;
      end
      S_EXE_BR: pc_wre = 1'b1;
      S_EXE_LS: state_d = S_MEM;
      S_MEM: begin
        state_d = op_lw ? S_WB_LD : S_IF;
        m_rd = op_lw;
        m_wr = op_sw;
        pc_wre = !op_lw;
      end
      S_WB_LD: begin
        pc_wre = 1'b1;
        reg_wre = 1'b1;
      end
      default: state_d = S_IF;
    endcase
  end
  assign bus.state = state_q;
  assign bus.PCWre = RST & pc_wre;
  assign bus.IRWre = RST & ir_wre;
  assign bus.RegWre = RST & reg_wre;
  assign bus.mRD = RST & m_rd;
  assign bus.mWR = RST & m_wr;
  assign bus.illegal = RST & ill;
  assign bus.ALUSrcB = op_addi | op_ori | op_lw | op_sw;
  assign bus.DBDataSrc = op_lw;
  assign bus.WrRegDSrc = !op_jal;
  assign bus.ExtSel = !op_ori;
  assign bus.RegDst = op_jal ? 2'b00 : is_r ? 2'b10 : 2'b01;
  assign bus.PCSrc = (op_j | op_jal) ? 2'b11 : op_jr ? 2'b10 :
                     (op_beq && state_q == S_EXE_BR && bus.zero) ? 2'b01 : 2'b00;
  assign bus.ALUOp = (op_sub | op_beq) ? 3'b001 : op_slt ? 3'b010 :
                     (op_or | op_ori) ? 3'b011 : op_and ? 3'b100 : 3'b000;
  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, pc_wre};
  // retired-instruction count: exactly one PC write per instruction
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign bus.instr_cnt = cnt_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: scoreboard bench with hand-computed per-cycle expectations
module tb_multi_cycle_ctrl;
  logic CLK = 1'b0;
  logic RST;
  multi_cycle_ctrl_if #(.CNT_W(32)) bus ();
  multi_cycle_ctrl #(.CNT_W(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  typedef struct packed {
    int id;
    logic [2:0] st;
    logic [5:0] stb;
    logic [10:0] sel;
    logic [10:0] msk;
    logic [31:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t e;
  event chk_ev;
  int checks = 0;
  int errors = 0;
  int n = 0;
  int id = 0;
  // strobes {PCWre, IRWre, RegWre, mRD, mWR, illegal}
  localparam logic [5:0] B_NONE = 6'b000000, B_IF = 6'b010000, B_PC = 6'b100000;
  localparam logic [5:0] B_PCREG = 6'b101000, B_RD = 6'b000100, B_SW = 6'b100010;
  localparam logic [5:0] B_ILL = 6'b100001;
  // selects {ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel, RegDst[1:0], PCSrc[1:0], ALUOp[2:0]}
  localparam logic [10:0] FULL = 11'b11111111111, NONE = 11'b0;
  localparam logic [10:0] SEL_ADD = 11'b00111000000, SEL_LW = 11'b11110100000;
  localparam logic [10:0] SEL_ORI = 11'b10100100011;
  localparam logic [10:0] SEL_SW = 11'b10110000000, M_SW = 11'b10110011111;
  localparam logic [10:0] SEL_JAL = 11'b00000011000, M_JAL = 11'b00101111000;
  localparam logic [10:0] SEL_JR = 11'b00000010000, M_PC = 11'b00000011000;
  localparam logic [10:0] SEL_BEQ1 = 11'b00000001001, SEL_BEQ0 = 11'b00000000001;
  localparam logic [10:0] M_BR = 11'b00000011111;
  task automatic check(input int i, input string what, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL step%0d %s: got %0h want %0h", i, what, got, want);
    end
  endtask
  initial forever begin
    @(negedge CLK or chk_ev);
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.id, "state", 32'(bus.state), 32'(e.st));
      check(e.id, "strobes", 32'({bus.PCWre, bus.IRWre, bus.RegWre, bus.mRD, bus.mWR, bus.illegal}), 32'(e.stb));
      if (e.msk != NONE)
        check(e.id, "selects", 32'({bus.ALUSrcB, bus.DBDataSrc, bus.WrRegDSrc, bus.ExtSel, bus.RegDst, bus.PCSrc, bus.ALUOp} & e.msk), 32'(e.sel & e.msk));
      check(e.id, "instr_cnt", bus.instr_cnt, e.cnt);
    end
  end
  task automatic push(input logic [2:0] st, input logic [5:0] stb, input logic [10:0] sel, input logic [10:0] msk);
    exp_t x;
    x.id = id;
    x.st = st;
    x.stb = stb;
    x.sel = sel;
    x.msk = msk;
    x.cnt = n;
    q.push_back(x);
    id++;
  endtask
  task automatic cyc(input logic [2:0] st, input logic [5:0] stb, input logic [10:0] sel, input logic [10:0] msk);
    push(st, stb, sel, msk);
    if (stb[5]) n++;
    @(posedge CLK);
    #1;
  endtask
  task automatic reset_now();
    RST = 1'b0;
    n = 0;
    #1;
    push(3'b000, B_NONE, NONE, NONE);
    ->chk_ev;
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask
  initial begin
    RST = 1'b0;
    bus.opcode = 6'b000000;
    bus.zero = 1'b0;
    #2;
    push(3'b000, B_NONE, SEL_ADD, FULL);
    ->chk_ev;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    cyc(3'b000, B_IF, SEL_ADD, FULL);
    cyc(3'b001, B_NONE, SEL_ADD, FULL);
    cyc(3'b110, B_NONE, SEL_ADD, FULL);
    cyc(3'b111, B_PCREG, SEL_ADD, FULL);
    bus.opcode = 6'b110001;
    cyc(3'b000, B_IF, SEL_LW, FULL);
    cyc(3'b001, B_NONE, SEL_LW, FULL);
    cyc(3'b010, B_NONE, SEL_LW, FULL);
    cyc(3'b011, B_RD, SEL_LW, FULL);
    cyc(3'b100, B_PCREG, SEL_LW, FULL);
    bus.opcode = 6'b110100;
    bus.zero = 1'b1;
    cyc(3'b000, B_IF, 11'b0, M_PC);
    cyc(3'b001, B_NONE, 11'b0, M_PC);
    cyc(3'b101, B_PC, SEL_BEQ1, M_BR);
    bus.zero = 1'b0;
    cyc(3'b000, B_IF, 11'b0, M_PC);
    cyc(3'b001, B_NONE, 11'b0, M_PC);
    cyc(3'b101, B_PC, SEL_BEQ0, M_BR);
    bus.opcode = 6'b111010;
    cyc(3'b000, B_IF, NONE, NONE);
    cyc(3'b001, B_PCREG, SEL_JAL, M_JAL);
    bus.opcode = 6'b010010;
    cyc(3'b000, B_IF, SEL_ORI, FULL);
    cyc(3'b001, B_NONE, SEL_ORI, FULL);
    cyc(3'b110, B_NONE, SEL_ORI, FULL);
    cyc(3'b111, B_PCREG, SEL_ORI, FULL);
    bus.opcode = 6'b111001;
    cyc(3'b000, B_IF, NONE, NONE);
    cyc(3'b001, B_PC, SEL_JR, M_PC);
    bus.opcode = 6'b101010;
    cyc(3'b000, B_IF, NONE, NONE);
    cyc(3'b001, B_ILL, NONE, NONE);
    bus.opcode = 6'b111111;
    cyc(3'b000, B_IF, NONE, NONE);
    for (int i = 0; i < 20; i++) cyc(3'b001, B_NONE, NONE, NONE);
    #2;
    reset_now();
    bus.opcode = 6'b110000;
    cyc(3'b000, B_IF, SEL_SW, M_SW);
    cyc(3'b001, B_NONE, SEL_SW, M_SW);
    cyc(3'b010, B_NONE, SEL_SW, M_SW);
    push(3'b011, B_SW, SEL_SW, M_SW);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    n = 0;
    #1;
    push(3'b000, B_NONE, SEL_SW, M_SW);
    ->chk_ev;
    @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
